// File: rtl/axi_wr_arbiter_if.sv
// One AXI write port (AW, W, B). The mst modport issues writes and the slv modport answers them.
// This interface only bundles signals, so it adds no latency and no backpressure of its own.
interface axi_wr_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 3
);
   localparam int IW = WIDTH / 8;

   logic [IW-1:0]    awid;
   logic [WIDTH-1:0] awaddr;
   logic [IW-1:0]    awlen;
   logic [SIZE-1:0]  awsize;
   logic [SIZE-2:0]  awburst;
   logic             awvalid;
   logic             awready;
   logic [IW-1:0]    wid;
   logic [WIDTH-1:0] wdata;
   logic [IW-1:0]    wstrb;
   logic             wlast;
   logic             wvalid;
   logic             wready;
   logic [IW-1:0]    bid;
   logic [SIZE-2:0]  bresp;
   logic             bvalid;
   logic             bready;

   modport mst (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wid, wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slv (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wid, wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-master write arbiter: a round-robin AW grant locks W and B to the owner, one transaction at a time.
// Grant takes one cycle; W and B pass straight through. Backpressure passes through to the owner, and the non-owner sees no ready.
module axi_wr_arbiter #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 3
) (
   input  logic          clk,
   input  logic          reset,
   axi_wr_arbiter_if.slv m0,
   axi_wr_arbiter_if.slv m1,
   axi_wr_arbiter_if.mst s,
   output logic [1:0]    grant,
   output logic          busy,
   output logic          wlast_err
);
   localparam int IW = WIDTH / 8;

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

   state_t        r_state;
   logic          r_owner;
   logic          r_last;
   logic          r_busy;
   logic          r_wlast_err;
   logic [1:0]    r_grant;
   logic [IW-1:0] r_len;
   logic [IW-1:0] r_beat;

   logic w_pick, w_req, w_in_addr, w_in_data, w_in_resp;
   logic w_aw_hs, w_w_hs, w_b_hs;

   // Under a tie the master that did not win last time gets the grant.
   assign w_req     = m0.awvalid | m1.awvalid;
   assign w_pick    = (m0.awvalid & m1.awvalid) ? ~r_last : m1.awvalid;
   assign w_in_addr = (r_state == ADDR);
   assign w_in_data = (r_state == DATA);
   assign w_in_resp = (r_state == RESP);

   assign s.awid    = r_owner ? m1.awid    : m0.awid;
   assign s.awaddr  = r_owner ? m1.awaddr  : m0.awaddr;
   assign s.awlen   = r_owner ? m1.awlen   : m0.awlen;
   assign s.awsize  = r_owner ? m1.awsize  : m0.awsize;
   assign s.awburst = r_owner ? m1.awburst : m0.awburst;
   assign s.awvalid = w_in_addr & (r_owner ? m1.awvalid : m0.awvalid);
   assign m0.awready = w_in_addr & ~r_owner & s.awready;
   assign m1.awready = w_in_addr &  r_owner & s.awready;

   assign s.wid    = r_owner ? m1.wid   : m0.wid;
   assign s.wdata  = r_owner ? m1.wdata : m0.wdata;
   assign s.wstrb  = r_owner ? m1.wstrb : m0.wstrb;
   assign s.wlast  = r_owner ? m1.wlast : m0.wlast;
   assign s.wvalid = w_in_data & (r_owner ? m1.wvalid : m0.wvalid);
   assign m0.wready = w_in_data & ~r_owner & s.wready;
   assign m1.wready = w_in_data &  r_owner & s.wready;

   assign s.bready  = w_in_resp & (r_owner ? m1.bready : m0.bready);
   assign m0.bvalid = w_in_resp & ~r_owner & s.bvalid;
   assign m1.bvalid = w_in_resp &  r_owner & s.bvalid;
   assign m0.bid    = s.bid;
   assign m1.bid    = s.bid;
   assign m0.bresp  = s.bresp;
   assign m1.bresp  = s.bresp;

   assign w_aw_hs = s.awvalid & s.awready;
   assign w_w_hs  = s.wvalid & s.wready;
   assign w_b_hs  = s.bvalid & s.bready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_owner     <= 1'b0;
         r_last      <= 1'b1;
         r_busy      <= 1'b0;
         r_grant     <= 2'b00;
         r_len       <= '0;
         r_beat      <= '0;
         r_wlast_err <= 1'b0;
      end else begin
         r_wlast_err <= 1'b0;
         case (r_state)
            IDLE: if (w_req) begin
               r_owner <= w_pick;
               r_last  <= w_pick;
               r_grant <= w_pick ? 2'b10 : 2'b01;
               r_busy  <= 1'b1;
               r_state <= ADDR;
            end
            ADDR: if (w_aw_hs) begin
               r_len   <= s.awlen;
               r_beat  <= '0;
               r_state <= DATA;
            end
            // The counter is compared before it increments, so a full 2^IW-beat burst wraps only afterwards.
            DATA: if (w_w_hs) begin
               r_beat      <= r_beat + IW'(1);
               r_wlast_err <= s.wlast ^ (r_beat == r_len);
               if (s.wlast) r_state <= RESP;
            end
            RESP: if (w_b_hs) begin
               r_grant <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant     = r_grant;
   assign busy      = r_busy;
   assign wlast_err = r_wlast_err;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: master and slave models, a scoreboard for AW, W and B, a vector table,
// and hand-written sequences for contention and for asynchronous reset.
module tb_axi_wr_arbiter;
   localparam int WIDTH = 32;
   localparam int SIZE  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant;
   logic       busy, wlast_err;

   axi_wr_arbiter_if #(.WIDTH(WIDTH), .SIZE(SIZE)) if_m0 ();
   axi_wr_arbiter_if #(.WIDTH(WIDTH), .SIZE(SIZE)) if_m1 ();
   axi_wr_arbiter_if #(.WIDTH(WIDTH), .SIZE(SIZE)) if_s ();

   axi_wr_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clk(clk), .reset(rst_n), .m0(if_m0), .m1(if_m1), .s(if_s),
      .grant(grant), .busy(busy), .wlast_err(wlast_err)
   );

   always #5 clk = ~clk;

   logic        md_awvalid [2];
   logic        md_wvalid  [2];
   logic        md_wlast   [2];
   logic        md_bready  [2];
   logic [31:0] md_awaddr  [2];
   logic [31:0] md_wdata   [2];
   logic [3:0]  md_awlen   [2];
   logic [3:0]  md_id      [2];
   logic        mr_awready [2];
   logic        mr_wready  [2];
   logic        mr_bvalid  [2];
   logic [3:0]  mr_bid     [2];
   logic [1:0]  mr_bresp   [2];

   assign if_m0.awid = md_id[0];        assign if_m1.awid = md_id[1];
   assign if_m0.awaddr = md_awaddr[0];  assign if_m1.awaddr = md_awaddr[1];
   assign if_m0.awlen = md_awlen[0];    assign if_m1.awlen = md_awlen[1];
   assign if_m0.awsize = 3'd2;          assign if_m1.awsize = 3'd2;
   assign if_m0.awburst = 2'd1;         assign if_m1.awburst = 2'd1;
   assign if_m0.awvalid = md_awvalid[0]; assign if_m1.awvalid = md_awvalid[1];
   assign if_m0.wid = md_id[0];         assign if_m1.wid = md_id[1];
   assign if_m0.wdata = md_wdata[0];    assign if_m1.wdata = md_wdata[1];
   assign if_m0.wstrb = 4'hF;           assign if_m1.wstrb = 4'hF;
   assign if_m0.wlast = md_wlast[0];    assign if_m1.wlast = md_wlast[1];
   assign if_m0.wvalid = md_wvalid[0];  assign if_m1.wvalid = md_wvalid[1];
   assign if_m0.bready = md_bready[0];  assign if_m1.bready = md_bready[1];
   assign mr_awready[0] = if_m0.awready; assign mr_awready[1] = if_m1.awready;
   assign mr_wready[0] = if_m0.wready;  assign mr_wready[1] = if_m1.wready;
   assign mr_bvalid[0] = if_m0.bvalid;  assign mr_bvalid[1] = if_m1.bvalid;
   assign mr_bid[0] = if_m0.bid;        assign mr_bid[1] = if_m1.bid;
   assign mr_bresp[0] = if_m0.bresp;    assign mr_bresp[1] = if_m1.bresp;

   typedef struct { int m; logic [31:0] addr; logic [3:0] len; } aw_t;
   typedef struct { int m; logic [31:0] data; logic last; } w_t;
   typedef struct { int m; logic [3:0] id; logic [1:0] resp; } b_t;
   typedef struct {
      int m; logic [31:0] addr; logic [3:0] len; int nb; int aw_hold; bit wtog; int exp_err;
   } vec_t;

   aw_t exp_aw[$];
   w_t  exp_w[$];
   b_t  exp_b[$];

   int total = 0;
   int bad = 0;
   int err_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no event want event", name);
   endtask

   // Slave: awready is held low for sl_aw_hold cycles of awvalid, and wready can toggle. B follows a WLAST beat.
   int         sl_aw_hold = 0;
   bit         sl_w_toggle = 1'b0;
   logic [3:0] sl_id = 4'h0;
   logic [31:0] sl_addr = 32'h0;
   initial begin
      bit aw_hs, wl_hs, b_hs;
      if_s.awready = 1'b1; if_s.wready = 1'b1; if_s.bvalid = 1'b0;
      if_s.bid = 4'h0; if_s.bresp = 2'b00;
      forever begin
         @(negedge clk);
         aw_hs = if_s.awvalid && if_s.awready;
         wl_hs = if_s.wvalid && if_s.wready && if_s.wlast;
         b_hs  = if_s.bvalid && if_s.bready;
         if (aw_hs) begin sl_id = if_s.awid; sl_addr = if_s.awaddr; end
         if (if_s.awvalid && sl_aw_hold > 0) sl_aw_hold--;
         @(posedge clk); #1;
         if (b_hs || !rst_n) if_s.bvalid = 1'b0;
         if (wl_hs) begin
            if_s.bvalid = 1'b1; if_s.bid = sl_id; if_s.bresp = sl_addr[13:12];
         end
         if_s.awready = (sl_aw_hold == 0);
         if_s.wready  = sl_w_toggle ? ~if_s.wready : 1'b1;
      end
   end

   // Monitor: pops the scoreboard when a handshake happens at the slave port and counts wlast_err pulses.
   initial begin
      aw_t ea; w_t ew; b_t eb;
      forever begin
         @(negedge clk);
         if (wlast_err === 1'b1) err_cnt++;
         if (if_s.awvalid && if_s.awready) begin
            if (exp_aw.size() == 0) fail_now("aw_unexpected");
            else begin
               ea = exp_aw.pop_front();
               chk("aw_addr", if_s.awaddr, ea.addr);
               chk("aw_len", 32'(if_s.awlen), 32'(ea.len));
               chk("aw_grant", 32'(grant), (ea.m != 0) ? 32'd2 : 32'd1);
               exp_b.push_back('{ea.m, (ea.m != 0) ? 4'hB : 4'hA, ea.addr[13:12]});
            end
         end
         if (if_s.wvalid && if_s.wready) begin
            if (exp_w.size() == 0) fail_now("w_unexpected");
            else begin
               ew = exp_w.pop_front();
               chk("w_data", if_s.wdata, ew.data);
               chk("w_last", 32'(if_s.wlast), 32'(ew.last));
               chk("w_nonowner_rdy", 32'(mr_wready[1-ew.m]), 32'd0);
            end
         end
         if (if_s.bvalid && if_s.bready) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else begin
               eb = exp_b.pop_front();
               chk("b_owner_vld", 32'(mr_bvalid[eb.m]), 32'd1);
               chk("b_other_vld", 32'(mr_bvalid[1-eb.m]), 32'd0);
               chk("b_id", 32'(mr_bid[eb.m]), 32'(eb.id));
               chk("b_resp", 32'(mr_bresp[eb.m]), 32'(eb.resp));
            end
         end
      end
   end

   task automatic wait_hs(input int m, input int ch, input string name);
      bit hit = 1'b0;
      for (int c = 0; c < 300 && !hit; c++) begin
         @(negedge clk);
         case (ch)
            0:       hit = md_awvalid[m] && mr_awready[m];
            1:       hit = md_wvalid[m] && mr_wready[m];
            default: hit = md_bready[m] && mr_bvalid[m];
         endcase
      end
      if (!hit) fail_now(name);
      @(posedge clk); #1;
   endtask

   task automatic mwr(input int m, input logic [31:0] addr, input logic [3:0] len, input int nb);
      logic [31:0] d;
      md_awaddr[m] = addr; md_awlen[m] = len; md_awvalid[m] = 1'b1;
      wait_hs(m, 0, "aw_timeout");
      md_awvalid[m] = 1'b0;
      for (int b = 0; b < nb; b++) begin
         d = addr + 32'(b);
         exp_w.push_back('{m, d, (b == nb - 1)});
      end
      for (int b = 0; b < nb; b++) begin
         md_wdata[m] = addr + 32'(b); md_wlast[m] = (b == nb - 1); md_wvalid[m] = 1'b1;
         wait_hs(m, 1, "w_timeout");
      end
      md_wvalid[m] = 1'b0; md_wlast[m] = 1'b0; md_bready[m] = 1'b1;
      wait_hs(m, 2, "b_timeout");
      md_bready[m] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want test end");
      $fatal(1, "watchdog expired");
   end

   vec_t       vt[6];
   logic [1:0] ghist[$];
   logic [1:0] gexp[5];
   logic [1:0] gseq[5];
   logic       bseq[5];
   int         e0;

   initial begin
      vt[0] = '{0, 32'h0000_0100, 4'd0, 1, 0, 1'b0, 0};
      vt[1] = '{1, 32'h0000_2200, 4'd3, 4, 0, 1'b0, 0};
      vt[2] = '{0, 32'h0000_1300, 4'd3, 4, 3, 1'b1, 0};
      vt[3] = '{1, 32'h0000_3400, 4'd3, 2, 0, 1'b0, 1};
      vt[4] = '{0, 32'h0000_0500, 4'd1, 3, 0, 1'b0, 2};
      vt[5] = '{1, 32'h0000_0600, 4'd15, 16, 0, 1'b1, 0};
      gexp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      gseq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
      bseq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int m = 0; m < 2; m++) begin
         md_awvalid[m] = 1'b1; md_wvalid[m] = 1'b1; md_wlast[m] = 1'b0; md_bready[m] = 1'b1;
         md_awaddr[m] = '0; md_wdata[m] = '0; md_awlen[m] = '0;
         md_id[m] = (m != 0) ? 4'hB : 4'hA;
      end

      // While reset is held, every output stays idle even though the masters are driving requests.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wlast_err", 32'(wlast_err), 32'd0);
      chk("rst_s_awvalid", 32'(if_s.awvalid), 32'd0);
      chk("rst_m0_awready", 32'(mr_awready[0]), 32'd0);
      chk("rst_s_bready", 32'(if_s.bready), 32'd0);
      for (int m = 0; m < 2; m++) begin
         md_awvalid[m] = 1'b0; md_wvalid[m] = 1'b0; md_bready[m] = 1'b0;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // A tie right after reset goes to M0, then to M1.
      exp_aw.push_back('{0, 32'h0000_1000, 4'd3});
      exp_aw.push_back('{1, 32'h0000_2000, 4'd3});
      fork
         mwr(0, 32'h0000_1000, 4'd3, 4);
         mwr(1, 32'h0000_2000, 4'd3, 4);
         begin
            for (int c = 0; c < 60; c++) begin
               @(negedge clk);
               if (ghist.size() == 0 || ghist[$] != grant) ghist.push_back(grant);
            end
         end
      join
      chk("tie_hist_len", 32'(ghist.size()), 32'd5);
      for (int i = 0; i < 5 && i < ghist.size(); i++)
         chk($sformatf("tie_hist_%0d", i), 32'(ghist[i]), 32'(gexp[i]));

      // Four back-to-back contended writes alternate between the masters.
      @(posedge clk); #1;
      exp_aw.push_back('{0, 32'h0000_3000, 4'd1});
      exp_aw.push_back('{1, 32'h0000_4000, 4'd1});
      exp_aw.push_back('{0, 32'h0000_3100, 4'd1});
      exp_aw.push_back('{1, 32'h0000_4100, 4'd1});
      fork
         begin mwr(0, 32'h0000_3000, 4'd1, 2); mwr(0, 32'h0000_3100, 4'd1, 2); end
         begin mwr(1, 32'h0000_4000, 4'd1, 2); mwr(1, 32'h0000_4100, 4'd1, 2); end
      join
      chk("rr_drained", 32'(exp_aw.size()), 32'd0);

      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         sl_aw_hold = vt[i].aw_hold;
         sl_w_toggle = vt[i].wtog;
         e0 = err_cnt;
         exp_aw.push_back('{vt[i].m, vt[i].addr, vt[i].len});
         mwr(vt[i].m, vt[i].addr, vt[i].len, vt[i].nb);
         sl_w_toggle = 1'b0;
         chk($sformatf("vec%0d_err_pulses", i), 32'(err_cnt - e0), 32'(vt[i].exp_err));
         chk($sformatf("vec%0d_busy_end", i), 32'(busy), 32'd0);
      end
      sl_aw_hold = 0;
      repeat (2) @(posedge clk);
      #1;

      // A single-beat M0 write with a ready slave passes through IDLE, ADDR, DATA, RESP and back to IDLE.
      exp_aw.push_back('{0, 32'h0000_0100, 4'd0});
      fork
         mwr(0, 32'h0000_0100, 4'd0, 1);
         begin
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk($sformatf("seq_grant_c%0d", c), 32'(grant), 32'(gseq[c]));
               chk($sformatf("seq_busy_c%0d", c), 32'(busy), 32'(bseq[c]));
            end
         end
      join

      // Assert reset in the middle of a burst, while beat 1 of 4 is being presented.
      @(posedge clk); #1;
      exp_aw.push_back('{1, 32'h0000_7000, 4'd3});
      md_awaddr[1] = 32'h0000_7000; md_awlen[1] = 4'd3; md_awvalid[1] = 1'b1;
      wait_hs(1, 0, "abort_aw");
      md_awvalid[1] = 1'b0;
      exp_w.push_back('{1, 32'h0000_7000, 1'b0});
      md_wdata[1] = 32'h0000_7000; md_wlast[1] = 1'b0; md_wvalid[1] = 1'b1;
      wait_hs(1, 1, "abort_w0");
      md_wdata[1] = 32'h0000_7001; md_bready[1] = 1'b1; md_awvalid[0] = 1'b1;
      chk("abort_pre_busy", 32'(busy), 32'd1);
      chk("abort_pre_wready", 32'(mr_wready[1]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_grant", 32'(grant), 32'd0);
      chk("abort_s_wvalid", 32'(if_s.wvalid), 32'd0);
      chk("abort_m1_wready", 32'(mr_wready[1]), 32'd0);
      chk("abort_s_awvalid", 32'(if_s.awvalid), 32'd0);
      chk("abort_m0_awready", 32'(mr_awready[0]), 32'd0);
      chk("abort_s_bready", 32'(if_s.bready), 32'd0);
      chk("abort_m1_bvalid", 32'(mr_bvalid[1]), 32'd0);
      exp_aw.delete(); exp_w.delete(); exp_b.delete();
      md_wvalid[1] = 1'b0; md_bready[1] = 1'b0; md_awvalid[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_aw.push_back('{1, 32'h0000_7100, 4'd0});
      fork
         mwr(1, 32'h0000_7100, 4'd0, 1);
         begin
            @(negedge clk);
            chk("post_rst_idle", 32'(grant), 32'd0);
            @(negedge clk);
            chk("post_rst_grant", 32'(grant), 32'd2);
         end
      join
      chk("final_drain", 32'(exp_aw.size() + exp_w.size() + exp_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
